// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential divider.
package div_pkg;

  // Default divisor/quotient/remainder width; the dividend is twice this.
  localparam int DEF_WIDTH = 8;

  // Width of the optional delivered-result counter.
  localparam int OP_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration.
// Compares the partial remainder against the divisor at full WIDTH+1 bits,
// subtracts when it fits, and reports the quotient bit produced.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   next_rem,
  output logic             qbit
);

  logic [WIDTH:0] divisor_ext;
  logic [WIDTH:0] diff;

  assign divisor_ext = {1'b0, divisor};
  assign diff        = rem - divisor_ext;

  // Restore (keep rem) when the divisor does not fit, otherwise take the difference.
  always_comb begin
    qbit     = 1'b0;
    next_rem = rem;
    if (rem >= divisor_ext) begin
      qbit     = 1'b1;
      next_rem = diff;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring unsigned divider, 2*WIDTH / WIDTH bits,
// one quotient bit per clock, valid/ready handshakes on both sides.
// Optional: define SEQ_DIVIDER_OP_COUNT_EN to add op_count, a wrapping
// count of delivered results (error results included).
//
// state | meaning
// IDLE  | waiting for operands; in_ready high
// RUN   | one shift/compare/subtract per cycle, WIDTH cycles total
// DONE  | result held on the outputs until out_ready
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_by_zero,
  output logic                 overflow
`ifdef SEQ_DIVIDER_OP_COUNT_EN
  ,
  output logic [OP_CNT_W-1:0]  op_count
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] low_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] divisor_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] dividend_hi;
  logic [WIDTH-1:0] dividend_lo;
  logic             accept;
  logic             deliver;
  logic             in_error;
  logic             last_iter;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   step_rem;
  logic             step_qbit;
  logic [WIDTH-1:0] quo_next;

  assign dividend_hi = dividend[2*WIDTH-1:WIDTH];
  assign dividend_lo = dividend[WIDTH-1:0];

  // in_ready is a registered copy of (state == IDLE), so it doubles as the state qualifier.
  assign accept  = in_valid && in_ready;
  assign deliver = out_valid && out_ready;

  // A quotient wider than WIDTH bits shows up as the high dividend half already >= divisor.
  assign in_error = (divisor == '0) || (dividend_hi >= divisor);

  assign last_iter = (cnt_q == CNT_W'(1));

  // Next partial remainder: shift left, pulling in the next dividend bit, MSB first.
  assign rem_shift = {rem_q[WIDTH-1:0], low_q[WIDTH-1]};
  assign quo_next  = {quo_q[WIDTH-2:0], step_qbit};

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem      (rem_shift),
    .divisor  (divisor_q),
    .next_rem (step_rem),
    .qbit     (step_qbit)
  );

  // Working datapath: operand capture on accept, one iteration per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q     <= '0;
      low_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
    end else if (state == IDLE) begin
      if (accept) begin
        rem_q     <= {1'b0, dividend_hi};
        low_q     <= dividend_lo;
        quo_q     <= '0;
        divisor_q <= divisor;
        cnt_q     <= CNT_W'(WIDTH);
      end
    end else if (state == RUN) begin
      rem_q <= step_rem;
      low_q <= {low_q[WIDTH-2:0], 1'b0};
      quo_q <= quo_next;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (in_error) begin
              // Errors skip the iterations; divide-by-zero wins over overflow.
              state       <= DONE;
              out_valid   <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend_lo;
              div_by_zero <= (divisor == '0);
              overflow    <= (divisor != '0);
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (last_iter) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            quotient    <= quo_next;
            remainder   <= step_rem[WIDTH-1:0];
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        DONE: begin
          // No bypass: a new operand pair is taken at the earliest one cycle later.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef SEQ_DIVIDER_OP_COUNT_EN
  // Count every delivered result; wraps naturally at 2^OP_CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (deliver) begin
      op_count <= op_count + OP_CNT_W'(1);
    end
  end
`else
  logic unused_deliver;
  assign unused_deliver = deliver;
`endif

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative restoring unsigned divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, giving a WIDTH-bit quotient and a WIDTH-bit remainder.
- Inverse companion to the Dadda multipliers: quotient*divisor + remainder reproduces the multiplier product.
- Produces one quotient bit per cycle, with valid/ready handshakes on input and output.
- Used as a reference/checker datapath and as a low-area divide unit beside the multiplier array.

Parameters:
- WIDTH, 8, divisor/quotient/remainder width; dividend is 2*WIDTH bits.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- dividend  input  2*WIDTH  unsigned dividend
- divisor  input  WIDTH  unsigned divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  WIDTH  unsigned quotient
- remainder  output  WIDTH  unsigned remainder
- div_by_zero  output  1  divisor was 0
- overflow  output  1  quotient does not fit in WIDTH bits

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values (rst high at an edge): state IDLE; in_ready=1; out_valid=0; quotient, remainder, div_by_zero, overflow all 0.
- Reset mid-operation: the in-flight operation is discarded with no partial output, and the same reset values apply.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready, latch the operands.
  - If divisor==0 or dividend[2W-1:W]>=divisor: go to DONE with the error result.
  - Otherwise go to RUN with iteration count=WIDTH.
- RUN:
  - in_ready=0.
  - Datapath: rem register is WIDTH+1 bits, initialised to {0, dividend[2W-1:W]}; low half held in a shift register.
  - Each cycle: rem={rem[W-1:0], next dividend bit (MSB first)}.
  - If rem>=divisor: rem-=divisor and shift 1 into the quotient; else shift 0.
  - Count decrements; at 0 go to DONE.
- DONE:
  - out_valid=1; outputs are registered and stable while out_ready=0.
  - On out_ready, go to IDLE and drop out_valid.
  - in_ready reasserts the cycle after the output handshake; there is no same-cycle bypass.
- Error result, with precedence div_by_zero > overflow:
  - quotient = all ones.
  - remainder = dividend[W-1:0].
  - The matching flag is 1 and the other flag is 0.
- Normal result: both flags 0; remainder < divisor is guaranteed.
- Latency (input handshake at edge T):
  - Normal: out_valid visible from cycle T+WIDTH+1.
  - Error: out_valid visible from cycle T+1.
  - Minimum initiation interval: WIDTH+2 cycles.
- Operands change while busy: in_valid and the operand inputs are ignored outside IDLE.
- out_ready while not out_valid: no effect.
- Width rules: all arithmetic is unsigned; the compare/subtract is WIDTH+1 bits wide; no truncation of rem before the compare.

Optional Feature:
- Macro: SEQ_DIVIDER_OP_COUNT_EN.
- When defined:
  - Adds output op_count (32 bits).
  - op_count increments on every output handshake (out_valid&&out_ready), including error results, and wraps at 2^32.
  - Reset value 0.
- When undefined: the port and the counter do not exist; all other behaviour is identical.

Decomposition:
- Package div_pkg holds:
  - typedef enum state_t {IDLE, RUN, DONE}.
  - Default WIDTH constant.
  - Counter width constant OP_CNT_W=32.
- One sub-module, div_step (combinational):
  - Inputs: rem (WIDTH+1 bits), divisor.
  - Outputs: next_rem and qbit.
  - Reused by the top-level datapath each RUN cycle.

Test Plan (WIDTH=8):
- 1000/7, out_ready=1 -> quotient=142, remainder=6, flags 0, out_valid exactly 9 cycles after accept.
- 0xFEFF/0xFF -> quotient=255, remainder=254, flags 0 (boundary just below overflow).
- Error cases:
  - 0x1234/0 -> div_by_zero=1, overflow=0, quotient=0xFF, remainder=0x34, out_valid 1 cycle after accept.
  - 0x1234/0x12 -> overflow=1, quotient=0xFF, remainder=0x34.
- Backpressure and back-to-back:
  - 200/3 with out_ready held low for 5 cycles -> outputs stay 66/2 and stable; in_ready stays 0 throughout.
  - in_ready rises the cycle after out_ready.
- Reset mid-operation:
  - rst pulsed in RUN cycle 4 -> next cycle out_valid=0, in_ready=1, all outputs 0.
  - Then 100/10 -> 10/0.
- With SEQ_DIVIDER_OP_COUNT_EN defined: 3 normal divisions plus 1 divide-by-zero -> op_count=4; rst -> 0.
